// File: rtl/encoder_scheduler_pkg.sv
// Shared constants and types for the 18->21 systematic encoder and its scheduler.
package enc_pkg;

  localparam int MSG_W = 18;
  localparam int CW_W  = 21;
  localparam int PAR_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    OUT
  } enc_state_t;

  typedef logic [MSG_W-1:0] message_t;
  typedef logic [CW_W-1:0]  codeword_t;

endpackage

// File: rtl/encoder_scheduler_if.sv
// Request and codeword handshake bundle between sources, scheduler and sink.
interface encoder_scheduler_if #(
  parameter int MSG_W = 18,
  parameter int CW_W  = 21
);

  logic             req0_valid;
  logic [MSG_W-1:0] req0_msg;
  logic             req0_ready;
  logic             req1_valid;
  logic [MSG_W-1:0] req1_msg;
  logic             req1_ready;
  logic             cw_valid;
  logic [CW_W-1:0]  cw_data;
  logic             cw_src;
  logic             cw_ready;

  modport master (
    output req0_valid, req0_msg, req1_valid, req1_msg, cw_ready,
    input  req0_ready, req1_ready, cw_valid, cw_data, cw_src
  );

  modport slave (
    input  req0_valid, req0_msg, req1_valid, req1_msg, cw_ready,
    output req0_ready, req1_ready, cw_valid, cw_data, cw_src
  );

endinterface

// File: rtl/encoder_scheduler_encoder.sv
// Combinational systematic encoder: message bits pass through, low bits repeat as parity.
module encoder
  import enc_pkg::*;
(
  input  message_t  b,
  output codeword_t c
);

  assign c = {b[PAR_W-1:0], b};

endmodule

// File: rtl/encoder_scheduler.sv
// Round-robin scheduler feeding two message sources through one shared encoder.
module encoder_scheduler #(
  parameter int MSG_W = 18,
  parameter int CW_W  = 21,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enc_en,
  encoder_scheduler_if.slave   bus,
  output logic [CNT_W-1:0]     cw_count,
  output logic                 busy
);
  import enc_pkg::*;

  enc_state_t       state, state_nxt;
  logic             last_grant;
  logic [MSG_W-1:0] msg_q;
  logic [CW_W-1:0]  cw_q;
  logic             src_q;
  codeword_t        enc_c;

  logic             prefer;
  logic             prefer_valid;
  logic             any_valid;
  logic             grant;
  logic             accept;

  encoder u_encoder (
    .b (msg_q),
    .c (enc_c)
  );

  // The source that did not win last time gets first refusal.
  always_comb begin
    prefer       = ~last_grant;
    prefer_valid = prefer ? bus.req1_valid : bus.req0_valid;
    any_valid    = bus.req0_valid | bus.req1_valid;
    grant        = prefer_valid ? prefer : ~prefer;
    accept       = (state == IDLE) & enc_en & any_valid;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ENC;
      ENC:     state_nxt = OUT;
      OUT:     if (bus.cw_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      msg_q      <= '0;
      cw_q       <= '0;
      src_q      <= 1'b0;
      cw_count   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        msg_q      <= grant ? bus.req1_msg : bus.req0_msg;
        src_q      <= grant;
        last_grant <= grant;
      end
      if (state == ENC)
        cw_q <= enc_c;
      if (state == OUT && bus.cw_ready)
        cw_count <= cw_count + CNT_W'(1);
    end
  end

  assign bus.req0_ready = accept & ~grant;
  assign bus.req1_ready = accept & grant;
  assign bus.cw_valid   = (state == OUT);
  assign bus.cw_data    = cw_q;
  assign bus.cw_src     = src_q;
  assign busy           = (state != IDLE);

endmodule
